// File: rtl/prio_arb_pkg.sv
// rtl/prio_arb_pkg.sv - shared types and helpers for the N-way priority arbiter
package prio_arb_pkg;

  typedef enum logic {MODE_FIXED, MODE_RR} mode_e;

  typedef enum logic {IDLE, GRANT} state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// rtl/prio_enc_n.sv - combinational N:W priority encoder, highest set index wins
module prio_enc_n
  import prio_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = W'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/prio_arb_n.sv
// rtl/prio_arb_n.sv - registered N-way arbiter, fixed or round-robin, valid/ready grant
module prio_arb_n
  import prio_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  state_e        state;
  logic [W-1:0]  ptr;
  mode_e         mode_sel;
  logic          accept;
  logic [W-1:0]  ptr_acc;
  logic [W-1:0]  ptr_arb;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]  req_rot;
  logic [W-1:0]  fix_idx, rot_idx, rr_idx, win_idx;
  logic          fix_any, rot_any, win_any;
  int            rr_sum;

  assign mode_sel = mode_e'(mode);
  assign accept   = (state == GRANT) && gnt_ready;
  // Accepting index k makes k the lowest priority: pointer moves to k-1, wrapping.
  assign ptr_acc  = (gnt_idx == '0) ? W'(N - 1) : gnt_idx - 1'b1;
  // Arbitration on an accept edge already sees the post-accept pointer.
  assign ptr_arb  = (accept && mode_sel == MODE_RR) ? ptr_acc : ptr;

  // Rotate so that requester ptr_arb lands on bit N-1, the encoder's top priority.
  assign req_dbl  = {req, req} >> (int'(ptr_arb) + 1);
  assign req_rot  = req_dbl[N-1:0];

  prio_enc_n #(.N(N), .W(W)) u_enc_fix (
    .req (req),
    .idx (fix_idx),
    .any (fix_any)
  );

  prio_enc_n #(.N(N), .W(W)) u_enc_rr (
    .req (req_rot),
    .idx (rot_idx),
    .any (rot_any)
  );

  always_comb begin
    rr_sum = int'(rot_idx) + int'(ptr_arb) + 1;
    if (rr_sum >= N) rr_sum = rr_sum - N;
    rr_idx = W'(rr_sum);
  end

  assign win_idx = (mode_sel == MODE_RR) ? rr_idx  : fix_idx;
  assign win_any = (mode_sel == MODE_RR) ? rot_any : fix_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= W'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_ready) begin
            if (mode_sel == MODE_RR) ptr <= ptr_acc;
            if (win_any) begin
              gnt_idx <= win_idx;
            end else begin
              gnt_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_onehot = gnt_valid ? (N'(1) << gnt_idx) : '0;

endmodule

// File: tb/tb_prio_arb_n.sv
// tb/tb_prio_arb_n.sv - directed self-checking bench for prio_arb_n at N=4
module tb_prio_arb_n;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         mode;
  logic         gnt_ready;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;

  int n_cmp = 0;
  int n_bad = 0;

  prio_arb_n #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mode       (mode),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    check({tag, "_valid"}, 64'(gnt_valid), 64'(1));
    check({tag, "_idx"}, 64'(gnt_idx), 64'(idx));
    check({tag, "_onehot"}, 64'(gnt_onehot), 64'(1) << idx);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 64'(gnt_valid), 64'(0));
    check({tag, "_idx"}, 64'(gnt_idx), 64'(0));
    check({tag, "_onehot"}, 64'(gnt_onehot), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int rr_seq[5] = '{3, 2, 1, 0, 3};
  int sp_seq[4] = '{3, 0, 3, 0};
  int sp_ptr[4] = '{3, 2, 3, 2};

  initial begin
    rst = 1'b1; req = '0; mode = 1'b0; gnt_ready = 1'b0;
    tick();
    expect_idle("reset");
    check("reset_ptr", 64'(dut.ptr), 64'(3));
    rst = 1'b0;

    // Fixed priority, repeated grant of the highest set index.
    req = 4'b0101; gnt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_grant($sformatf("fixed%0d", i), 2);
    end

    // Stall on index 3 while requests change underneath.
    req = 4'b1000;
    tick();
    expect_grant("stall_first", 3);
    gnt_ready = 1'b0; req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_grant($sformatf("stall%0d", i), 3);
    end
    gnt_ready = 1'b1;
    tick();
    expect_grant("stall_after", 0);

    // No requests: back to idle; ready while idle changes nothing.
    req = 4'b0000;
    tick();
    check("idle_valid", 64'(gnt_valid), 64'(0));
    check("idle_onehot", 64'(gnt_onehot), 64'(0));
    tick();
    check("idle2_valid", 64'(gnt_valid), 64'(0));
    check("idle_fixed_ptr", 64'(dut.ptr), 64'(3));

    // Round-robin full rotation with wrap.
    do_reset();
    mode = 1'b1; req = 4'b1111; gnt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_grant($sformatf("rr%0d", i), rr_seq[i]);
    end

    // Round-robin sparse requests.
    do_reset();
    mode = 1'b1; req = 4'b1001; gnt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_grant($sformatf("sparse%0d", i), sp_seq[i]);
      check($sformatf("sparse_ptr%0d", i), 64'(dut.ptr), 64'(sp_ptr[i]));
    end

    // Reset in the middle of a stalled grant.
    do_reset();
    mode = 1'b0; req = 4'b0100; gnt_ready = 1'b0;
    tick();
    expect_grant("pre_rst0", 2);
    tick();
    expect_grant("pre_rst1", 2);
    rst = 1'b1;
    tick();
    expect_idle("mid_rst");
    check("mid_rst_ptr", 64'(dut.ptr), 64'(3));
    rst = 1'b0; mode = 1'b1; req = 4'b1111; gnt_ready = 1'b1;
    tick();
    expect_grant("post_rst", 3);

    // Mode change while stalled on index 1.
    req = 4'b1010;
    tick();
    expect_grant("ms_grant", 1);
    check("ms_ptr", 64'(dut.ptr), 64'(2));
    gnt_ready = 1'b0; mode = 1'b0;
    tick();
    expect_grant("ms_hold0", 1);
    tick();
    expect_grant("ms_hold1", 1);
    gnt_ready = 1'b1;
    tick();
    expect_grant("ms_fixed", 3);
    check("ms_ptr_kept", 64'(dut.ptr), 64'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
